// File: rtl/bht_updq_pkg.sv
// Shared types for the BHT update issuer: branch type, queued update record, pointer sizing.
package bht_updq_pkg;

    // Widest PC the queued record can carry; the top truncates/extends to its VLEN.
    localparam int BHT_VLEN = 64;

    typedef enum logic {
        JUMP        = 1'b0,
        CONDITIONAL = 1'b1
    } branch_type_e;

    typedef struct packed {
        logic [BHT_VLEN-1:0] pc;
        logic                taken;
        logic                mispredict;
    } bht_upd_t;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bht_updq_fifo.sv
// Update queue storage: DEPTH entries, wrap-bit pointers, full/empty/occupancy status.
module bht_updq_fifo
    import bht_updq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  bht_upd_t             wdata_i,
    input  logic                 pop_i,
    output bht_upd_t             rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    bht_upd_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // A pop in the same cycle frees the slot the push lands in, so full only blocks a lone push.
    assign pop_ok_s  = pop_i & ~empty_s;
    assign push_ok_s = push_i & (~full_s | pop_ok_s);

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= wdata_i;
        end
    end

    // Head entry, zeroed when empty so stale data never shows on the interface.
    always_comb begin
        if (empty_s) begin
            rdata_o = '0;
        end else begin
            rdata_o = mem_r[rd_ptr_r[IDX_W-1:0]];
        end
    end

    assign full_o      = full_s;
    assign empty_o     = empty_s;
    assign occupancy_o = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/bht_update_issuer.sv
// Predictor update issuer: filters JUMP resolutions, queues conditional ones, issues one per cycle.
// Optional BHT_UPDQ_BYPASS_EN forwards a resolution straight to the predictor when the queue is empty.
module bht_update_issuer
    import bht_updq_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   res_valid_i,
    input  logic [VLEN-1:0]        res_pc_i,
    input  logic                   res_type_i,
    input  logic                   res_taken_i,
    input  logic                   res_mispredict_i,
    output logic                   res_ready_o,
    output logic                   upd_valid_o,
    output logic [VLEN-1:0]        upd_pc_o,
    output logic                   upd_taken_o,
    output logic                   upd_mispredict_o,
    input  logic                   upd_ready_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [CNT_W-1:0]       drop_cnt_o
);

    bht_upd_t   wdata_s;
    bht_upd_t   head_s;
    bht_upd_t   out_s;
    logic       cond_s;
    logic       full_s;
    logic       empty_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;
    logic       bypass_s;
    logic       valid_s;
    logic [CNT_W-1:0] drop_cnt_r;

    assign cond_s  = res_valid_i && (branch_type_e'(res_type_i) == CONDITIONAL);
    assign wdata_s = '{pc: BHT_VLEN'(res_pc_i), taken: res_taken_i, mispredict: res_mispredict_i};

`ifdef BHT_UPDQ_BYPASS_EN
    assign bypass_s = cond_s & empty_s & upd_ready_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign valid_s = ~empty_s | bypass_s;
    assign pop_s   = ~empty_s & upd_ready_i;
    assign push_s  = cond_s & ~bypass_s & (~full_s | pop_s);
    assign drop_s  = cond_s & full_s & ~pop_s;

    bht_updq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_s),
        .wdata_i     (wdata_s),
        .pop_i       (pop_s),
        .rdata_o     (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .occupancy_o (occupancy_o)
    );

    // Saturating count of conditional resolutions lost to a full queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
    end

    // Select the forwarded resolution or the queue head for the update interface.
    always_comb begin
        if (bypass_s) begin
            out_s = wdata_s;
        end else begin
            out_s = head_s;
        end
    end

    assign upd_valid_o      = valid_s;
    assign upd_pc_o         = out_s.pc[VLEN-1:0];
    assign upd_taken_o      = out_s.taken;
    assign upd_mispredict_o = out_s.mispredict;
    assign res_ready_o      = ~full_s | (valid_s & upd_ready_i);
    assign drop_cnt_o       = drop_cnt_r;

endmodule
